// File: rtl/mv_decode_sequencer.sv
// ---- mv_decode_sequencer: drives get_motion_code and rebuilds one wrapped MPEG-2 motion vector (H then V) per start
// ---- Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module mv_decode_sequencer (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         f_code_h,
  input  logic [3:0]         f_code_v,
  input  logic signed [12:0] pmv_h,
  input  logic signed [12:0] pmv_v,
  input  logic [31:0]        bs_bits,
  input  logic               bs_valid,
  output logic               bs_adv,
  output logic [4:0]         bs_len,
  output logic [10:0]        gmc_buf,
  output logic               gmc_in_valid,
  input  logic [4:0]         gmc_outshift,
  input  logic [4:0]         gmc_mcode,
  output logic signed [12:0] mv_h,
  output logic signed [12:0] mv_v,
  output logic               mv_valid,
  output logic               busy,
  output logic               err
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    H_CODE = 4'd1,
    H_WAIT = 4'd2,
    H_RES  = 4'd3,
    H_CALC = 4'd4,
    V_CODE = 4'd5,
    V_WAIT = 4'd6,
    V_RES  = 4'd7,
    V_CALC = 4'd8,
    DONE   = 4'd9
  } state_t;

  state_t             state;
  logic [3:0]         fcode_h_l;
  logic [3:0]         fcode_v_l;
  logic signed [12:0] pmv_h_l;
  logic signed [12:0] pmv_v_l;
  logic [4:0]         mag;
  logic               sgn;
  logic [7:0]         res;

  logic               is_v;
  logic [3:0]         cur_f;
  logic [3:0]         rsz;
  logic signed [12:0] cur_pmv;
  logic [4:0]         mcode_abs;
  logic               code_sign;
  logic [7:0]         resid;
  logic [14:0]        delta;
  logic signed [14:0] span;
  logic signed [14:0] sum;
  logic signed [12:0] mv_next;
  logic               win_ok;
  logic               start_bad;

  assign gmc_buf = bs_bits[31:21];

  // A window is never trusted in the cycle our own bs_adv is still showing.
  assign win_ok = bs_valid && !bs_adv;

  assign start_bad = (f_code_h == 4'd0) || (f_code_h > 4'd9) ||
                     (f_code_v == 4'd0) || (f_code_v > 4'd9);

  always_comb begin
    is_v      = (state == V_CODE) || (state == V_WAIT) ||
                (state == V_RES)  || (state == V_CALC);
    cur_f     = is_v ? fcode_v_l : fcode_h_l;
    rsz       = cur_f - 4'd1;
    cur_pmv   = is_v ? pmv_v_l : pmv_h_l;
    // 5'b10000 negates to itself, which reads as an unsigned 16.
    mcode_abs = gmc_mcode[4] ? (~gmc_mcode + 5'd1) : gmc_mcode;
    code_sign = bs_bits[5'd31 - (gmc_outshift - 5'd1)];
    resid     = bs_bits[31:24] >> (4'd8 - rsz);
    delta     = 15'd0;
    if (mag != 5'd0)
      delta = ({10'd0, mag - 5'd1} << rsz) + {7'd0, res} + 15'd1;
    span      = 15'sd16 <<< rsz;
    sum       = $signed({{2{cur_pmv[12]}}, cur_pmv}) +
                (sgn ? -$signed(delta) : $signed(delta));
    if (sum > span - 15'sd1)
      mv_next = 13'(sum - (span <<< 1));
    else if (sum < -span)
      mv_next = 13'(sum + (span <<< 1));
    else
      mv_next = 13'(sum);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      fcode_h_l    <= 4'd0;
      fcode_v_l    <= 4'd0;
      pmv_h_l      <= 13'sd0;
      pmv_v_l      <= 13'sd0;
      mag          <= 5'd0;
      sgn          <= 1'b0;
      res          <= 8'd0;
      bs_adv       <= 1'b0;
      bs_len       <= 5'd0;
      gmc_in_valid <= 1'b0;
      mv_h         <= 13'sd0;
      mv_v         <= 13'sd0;
      mv_valid     <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      bs_adv       <= 1'b0;
      gmc_in_valid <= 1'b0;
      mv_valid     <= 1'b0;
      err          <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            fcode_h_l <= f_code_h;
            fcode_v_l <= f_code_v;
            pmv_h_l   <= pmv_h;
            pmv_v_l   <= pmv_v;
            if (start_bad) begin
              err <= 1'b1;
            end else begin
              state <= H_CODE;
              busy  <= 1'b1;
            end
          end
        end
        H_CODE, V_CODE: begin
          if (win_ok) begin
            gmc_in_valid <= 1'b1;
            state        <= (state == H_CODE) ? H_WAIT : V_WAIT;
          end
        end
        H_WAIT, V_WAIT: begin
          mag    <= (gmc_outshift > 5'd1) ? mcode_abs : 5'd0;
          sgn    <= (gmc_outshift > 5'd1) && code_sign;
          res    <= 8'd0;
          bs_adv <= 1'b1;
          bs_len <= gmc_outshift;
          if ((rsz != 4'd0) && (gmc_outshift > 5'd1) && (mcode_abs != 5'd0))
            state <= (state == H_WAIT) ? H_RES : V_RES;
          else
            state <= (state == H_WAIT) ? H_CALC : V_CALC;
        end
        H_RES, V_RES: begin
          if (win_ok) begin
            res    <= resid;
            bs_adv <= 1'b1;
            bs_len <= {1'b0, rsz};
            state  <= (state == H_RES) ? H_CALC : V_CALC;
          end
        end
        H_CALC: begin
          mv_h  <= mv_next;
          state <= V_CODE;
        end
        V_CALC: begin
          // mv_valid is raised on entry so it is visible while in DONE.
          mv_v     <= mv_next;
          mv_valid <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mv_decode_sequencer.sv
// ---- tb_mv_decode_sequencer: scoreboard bench with bitstream feeder and motion-code decoder stub
// ---- Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_mv_decode_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               start;
  logic [3:0]         f_code_h;
  logic [3:0]         f_code_v;
  logic signed [12:0] pmv_h;
  logic signed [12:0] pmv_v;
  logic [31:0]        bs_bits;
  logic               bs_valid;
  logic               bs_adv;
  logic [4:0]         bs_len;
  logic [10:0]        gmc_buf;
  logic               gmc_in_valid;
  logic [4:0]         gmc_outshift;
  logic [4:0]         gmc_mcode;
  logic signed [12:0] mv_h;
  logic signed [12:0] mv_v;
  logic               mv_valid;
  logic               busy;
  logic               err;

  mv_decode_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .f_code_h     (f_code_h),
    .f_code_v     (f_code_v),
    .pmv_h        (pmv_h),
    .pmv_v        (pmv_v),
    .bs_bits      (bs_bits),
    .bs_valid     (bs_valid),
    .bs_adv       (bs_adv),
    .bs_len       (bs_len),
    .gmc_buf      (gmc_buf),
    .gmc_in_valid (gmc_in_valid),
    .gmc_outshift (gmc_outshift),
    .gmc_mcode    (gmc_mcode),
    .mv_h         (mv_h),
    .mv_v         (mv_v),
    .mv_valid     (mv_valid),
    .busy         (busy),
    .err          (err)
  );

  typedef struct {
    int h;
    int v;
    int lat;
  } mv_exp_t;

  mv_exp_t exp_mv[$];
  int      exp_adv[$];
  int      exp_err[$];

  int n_vec     = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int start_cyc = 0;
  int req_cnt   = 0;
  int load_id   = 0;
  int seen_id   = 0;

  logic [255:0] win        = '0;
  logic [255:0] new_stream = '0;
  logic         hold       = 1'b0;

  assign bs_bits  = win[255:224];
  assign bs_valid = !hold && !bs_adv;

  always @(posedge clk) cyc <= cyc + 1;

  // Feeder: drops bits mid-cycle while bs_adv is showing; its valid is low then.
  always @(negedge clk) begin
    if (load_id != seen_id) begin
      win     = new_stream;
      seen_id = load_id;
    end else if (bs_adv) begin
      win = win << bs_len;
    end
  end

  // Decoder stub covering only the codes used below; signed motion code out.
  always_comb begin
    gmc_outshift = 5'd0;
    gmc_mcode    = 5'd0;
    if (gmc_buf[10]) begin
      gmc_outshift = 5'd1;
    end else if (gmc_buf[10:9] == 2'b01) begin
      gmc_outshift = 5'd3;
      gmc_mcode    = gmc_buf[8] ? 5'h1F : 5'd1;
    end else if (gmc_buf[10:8] == 3'b001) begin
      gmc_outshift = 5'd4;
      gmc_mcode    = gmc_buf[7] ? 5'h1E : 5'd2;
    end else if (gmc_buf[10:7] == 4'b0001) begin
      gmc_outshift = 5'd5;
      gmc_mcode    = gmc_buf[6] ? 5'h1D : 5'd3;
    end else if (gmc_buf[10:1] == 10'b0000001100) begin
      gmc_outshift = 5'd11;
      gmc_mcode    = 5'b10000;
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic logic [255:0] to_bits(input string s);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < s.len(); i++)
      if (s[i] == "1") v[255-i] = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    mv_exp_t e;
    if (gmc_in_valid) req_cnt++;
    if (bs_adv) begin
      chk("bs_adv_expected", (exp_adv.size() > 0) ? 1 : 0, 1);
      if (exp_adv.size() > 0) chk("bs_len", int'(bs_len), exp_adv.pop_front());
    end
    if (mv_valid) begin
      chk("mv_valid_expected", (exp_mv.size() > 0) ? 1 : 0, 1);
      if (exp_mv.size() > 0) begin
        e = exp_mv.pop_front();
        chk("mv_h", int'(mv_h), e.h);
        chk("mv_v", int'(mv_v), e.v);
        chk("mv_latency", cyc - start_cyc, e.lat);
      end
    end
    if (err) begin
      chk("err_expected", (exp_err.size() > 0) ? 1 : 0, 1);
      if (exp_err.size() > 0) chk("err_latency", cyc - start_cyc, exp_err.pop_front());
    end
  end

  task automatic launch(input logic [3:0] fh, input logic [3:0] fv,
                        input logic signed [12:0] ph, input logic signed [12:0] pv,
                        input string bits);
    new_stream = to_bits(bits);
    load_id++;
    @(negedge clk);
    f_code_h  = fh;
    f_code_v  = fv;
    pmv_h     = ph;
    pmv_v     = pv;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      if (exp_mv.size() == 0 && !busy) break;
      @(negedge clk);
    end
    chk("decode_finished", int'(exp_mv.size()) + int'(busy), 0);
    exp_mv.delete();
    @(negedge clk);
  endtask

  initial begin
    int act;
    rst = 1'b0; start = 1'b0;
    f_code_h = 4'd0; f_code_v = 4'd0; pmv_h = 13'sd0; pmv_v = 13'sd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pulses", int'({bs_adv, gmc_in_valid, mv_valid, err}), 0);
    chk("reset_vectors", int'(mv_h) + int'(mv_v) + int'(bs_len), 0);
    rst = 1'b1;
    @(negedge clk);

    // No residual, f_code 1/1.
    exp_adv.push_back(1); exp_adv.push_back(3);
    exp_mv.push_back('{5, -2, 7});
    launch(4'd1, 4'd1, 13'sd5, -13'sd3, "1010");
    wait_done();

    // Residuals on both components; V uses a negative decoder motion code.
    exp_adv.push_back(4); exp_adv.push_back(2);
    exp_adv.push_back(4); exp_adv.push_back(1);
    exp_mv.push_back('{16, -4, 11});
    launch(4'd3, 4'd2, 13'sd10, 13'sd0, "00100100111");
    wait_done();

    // Wrap-around both ways, with a start fired mid-decode that must be ignored.
    exp_adv.push_back(3); exp_adv.push_back(3);
    exp_mv.push_back('{-16, 15, 7});
    launch(4'd1, 4'd1, 13'sd15, -13'sd16, "010011");
    @(negedge clk);
    f_code_h = 4'd0; pmv_h = 13'sd1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Magnitude 16 code, 11 bits long.
    exp_adv.push_back(11); exp_adv.push_back(1);
    exp_mv.push_back('{-16, 0, 7});
    launch(4'd1, 4'd1, 13'sd0, 13'sd0, "000000110011");
    wait_done();

    // Illegal f_codes: zero horizontal, then ten vertical.
    exp_err.push_back(1);
    launch(4'd0, 4'd1, 13'sd0, 13'sd0, "1");
    act = 0;
    repeat (5) begin
      act = act | int'(busy) | int'(gmc_in_valid);
      @(negedge clk);
    end
    chk("err_fcode0_idle", act, 0);
    exp_err.push_back(1);
    launch(4'd1, 4'd10, 13'sd0, 13'sd0, "1");
    act = 0;
    repeat (5) begin
      act = act | int'(busy) | int'(gmc_in_valid);
      @(negedge clk);
    end
    chk("err_fcode10_idle", act, 0);
    chk("err_all_seen", int'(exp_err.size()), 0);

    // Abort with reset while stalled waiting for a residual.
    exp_adv.push_back(3);
    launch(4'd3, 4'd1, 13'sd7, 13'sd7, "0100");
    for (int i = 0; i < 20 && !bs_adv; i++) @(negedge clk);
    chk("abort_code_consumed", int'(bs_adv), 1);
    hold = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_stalled_busy", int'(busy), 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_pulses", int'({bs_adv, gmc_in_valid, mv_valid, err}), 0);
    chk("abort_mv_h", int'(mv_h), 0);
    chk("abort_mv_v_len", int'(mv_v) + int'(bs_len), 0);
    hold = 1'b0;
    @(negedge clk);

    // Fresh decode after the abort, one residual.
    exp_adv.push_back(3); exp_adv.push_back(1); exp_adv.push_back(1);
    exp_mv.push_back('{-6, 3, 9});
    launch(4'd2, 4'd1, -13'sd7, 13'sd3, "01001");
    wait_done();

    repeat (3) @(negedge clk);
    chk("decoder_requests", req_cnt, 11);
    chk("bs_adv_all_seen", int'(exp_adv.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
